// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes,
// 4-bit state encodings, datapath mux codes and small opcode helpers.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_RTEXE   = 4'd7,
        ST_MULWAIT = 4'd8,
        ST_RTWB    = 4'd9,
        ST_BEQ     = 4'd10,
        ST_JUMP    = 4'd11,
        ST_IEXE    = 4'd12,
        ST_IWB     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_ADDI = 2'b01;
    localparam logic [1:0] IMM_ANDI = 2'b10;
    localparam logic [1:0] IMM_SLTI = 2'b11;

    // immedateop code for an I-type ALU opcode; IMM_NONE for anything else
    function automatic logic [1:0] imm_kind(input logic [5:0] op);
        case (op)
            OP_ADDI: imm_kind = IMM_ADDI;
            OP_ANDI: imm_kind = IMM_ANDI;
            OP_SLTI: imm_kind = IMM_SLTI;
            default: imm_kind = IMM_NONE;
        endcase
    endfunction

    // true for every opcode this controller can sequence
    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_SLTI: is_supported = 1'b1;
            default:                   is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mul_stall_counter.sv
// Down-counter that times the MULWAIT stall. It is loaded with the number
// of extra EXE cycles; 'last' flags the final stall cycle, i.e. the cycle
// whose decrement brings the count to zero.
module mul_stall_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    // load has priority; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/multicycle_control.sv
// Moore main-control FSM for the multi-cycle MIPS datapath. Steps each
// instruction through fetch/decode/execute/memory/writeback and stalls in
// EXE for the multi-cycle multiply (funct[3:0] == 4'b1111).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic [1:0] immedateop,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam int CNT_W     = $clog2(MUL_CYCLES) + 1;
    localparam bit MUL_STALL = (MUL_CYCLES > 1);

    state_t     state_q, state_d;
    logic [1:0] imm_q, imm_d;
    logic       is_mul;
    logic       cnt_load, cnt_dec, cnt_last;

    // zero gates the PC load in the datapath and only the low funct bits
    // select mul, so these inputs are intentionally not consumed here
    logic unused_inputs;
    assign unused_inputs = ^{funct[5:4], zero};

    assign is_mul   = (funct[3:0] == 4'b1111);
    assign cnt_load = MUL_STALL && (state_q == ST_RTEXE) && is_mul;
    assign cnt_dec  = (state_q == ST_MULWAIT);

    mul_stall_counter #(
        .W (CNT_W)
    ) u_mul_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (CNT_W'(MUL_CYCLES - 1)),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    // state and latched immediate kind; reset aborts any instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            imm_q   <= IMM_NONE;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
        end
    end

    // next-state decode; the immediate kind is captured in DECODE so that
    // immedateop stays a function of registered state in IEXE/IWB
    always_comb begin
        state_d = ST_FETCH;
        imm_d   = imm_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                imm_d = imm_kind(opcode);
                case (opcode)
                    OP_RTYPE:                  state_d = ST_RTEXE;
                    OP_LW, OP_SW:              state_d = ST_MEMADR;
                    OP_BEQ:                    state_d = ST_BEQ;
                    OP_J:                      state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_SLTI: state_d = ST_IEXE;
                    default:                   state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   state_d = ST_MEMWB;
            ST_RTEXE:   state_d = (MUL_STALL && is_mul) ? ST_MULWAIT : ST_RTWB;
            ST_MULWAIT: state_d = cnt_last ? ST_RTWB : ST_MULWAIT;
            ST_IEXE:    state_d = ST_IWB;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; illegal_op is the one flag qualified by opcode
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        pcsource    = PCSRC_ALU;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        immedateop  = IMM_NONE;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
            end
            ST_DECODE: begin
                alusrcb    = SRCB_IMMSH2;
                illegal_op = !is_supported(opcode);
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ST_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
            end
            ST_RTEXE, ST_MULWAIT: begin
                alusrca = 1'b1;
                alusrcb = SRCB_RT;
                aluop1  = 1'b1;
            end
            ST_RTWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            ST_BEQ: begin
                alusrca     = 1'b1;
                alusrcb     = SRCB_RT;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            ST_JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_IEXE: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                immedateop = imm_q;
            end
            ST_IWB: begin
                regwrite   = 1'b1;
                immedateop = imm_q;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle and compares the full control word against hand-built
// per-state expectations.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
    logic       instr_done, illegal_op;
    logic [1:0] alusrcb, pcsource, immedateop;

    int errors = 0;
    int checks = 0;

    multicycle_control #(
        .MUL_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsource    (pcsource),
        .aluop1      (aluop1),
        .aluop0      (aluop0),
        .immedateop  (immedateop),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    // control word: pcwrite pcwritecond iord memread memwrite irwrite
    //               memtoreg regdst regwrite alusrca alusrcb pcsource
    //               aluop1 aluop0 immedateop instr_done illegal_op
    logic [19:0] ctrl;
    assign ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                   memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
                   aluop1, aluop0, immedateop, instr_done, illegal_op};

    localparam logic [19:0] W_ZERO   = 20'b0_0_0_0_0_0_0_0_0_0_00_00_0_0_00_0_0;
    localparam logic [19:0] W_FETCH  = 20'b1_0_0_1_0_1_0_0_0_0_01_00_0_0_00_0_0;
    localparam logic [19:0] W_DECODE = 20'b0_0_0_0_0_0_0_0_0_0_11_00_0_0_00_0_0;
    localparam logic [19:0] W_DECILL = 20'b0_0_0_0_0_0_0_0_0_0_11_00_0_0_00_0_1;
    localparam logic [19:0] W_MEMADR = 20'b0_0_0_0_0_0_0_0_0_1_10_00_0_0_00_0_0;
    localparam logic [19:0] W_MEMRD  = 20'b0_0_1_1_0_0_0_0_0_0_00_00_0_0_00_0_0;
    localparam logic [19:0] W_MEMWB  = 20'b0_0_0_0_0_0_1_0_1_0_00_00_0_0_00_1_0;
    localparam logic [19:0] W_MEMWR  = 20'b0_0_1_0_1_0_0_0_0_0_00_00_0_0_00_1_0;
    localparam logic [19:0] W_RTEXE  = 20'b0_0_0_0_0_0_0_0_0_1_00_00_1_0_00_0_0;
    localparam logic [19:0] W_RTWB   = 20'b0_0_0_0_0_0_0_1_1_0_00_00_0_0_00_1_0;
    localparam logic [19:0] W_BEQ    = 20'b0_1_0_0_0_0_0_0_0_1_00_01_0_1_00_1_0;
    localparam logic [19:0] W_JUMP   = 20'b1_0_0_0_0_0_0_0_0_0_00_10_0_0_00_1_0;
    localparam logic [19:0] W_IEXE_A = 20'b0_0_0_0_0_0_0_0_0_1_10_00_0_0_01_0_0;
    localparam logic [19:0] W_IEXE_N = 20'b0_0_0_0_0_0_0_0_0_1_10_00_0_0_10_0_0;
    localparam logic [19:0] W_IEXE_S = 20'b0_0_0_0_0_0_0_0_0_1_10_00_0_0_11_0_0;
    localparam logic [19:0] W_IWB_A  = 20'b0_0_0_0_0_0_0_0_1_0_00_00_0_0_01_1_0;
    localparam logic [19:0] W_IWB_N  = 20'b0_0_0_0_0_0_0_0_1_0_00_00_0_0_10_1_0;
    localparam logic [19:0] W_IWB_S  = 20'b0_0_0_0_0_0_0_0_1_0_00_00_0_0_11_1_0;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ctrl !== W_ZERO) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", ctrl, W_ZERO);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl !== W_ZERO) begin
            errors++;
            $display("FAIL idle_after_release: got %b expected %b", ctrl, W_ZERO);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctrl !== W_FETCH) begin
            errors++;
            $display("FAIL fetch_after_idle: got %b expected %b", ctrl, W_FETCH);
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [19:0] seq [4];
        seq = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD};
        opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl !== seq[i]) begin
                errors++;
                $display("FAIL lw_abort cycle %0d: got %b expected %b", i + 1, ctrl, seq[i]);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== W_ZERO) begin
            errors++;
            $display("FAIL async_reset_mid_memrd: got %b expected %b", ctrl, W_ZERO);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== 1'b0) begin
                errors++;
                $display("FAIL no_regwrite_in_reset: got %b expected 0", regwrite);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl !== W_ZERO) begin
            errors++;
            $display("FAIL idle_after_abort: got %b expected %b", ctrl, W_ZERO);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctrl !== W_FETCH) begin
            errors++;
            $display("FAIL fetch_after_abort: got %b expected %b", ctrl, W_FETCH);
        end
    endtask

    task automatic test_r_add();
        logic [19:0] seq [4];
        seq = '{W_FETCH, W_DECODE, W_RTEXE, W_RTWB};
        opcode = 6'b000000;
        funct  = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl !== seq[i]) begin
                errors++;
                $display("FAIL r_add cycle %0d: got %b expected %b", i + 1, ctrl, seq[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_r_mul();
        logic [19:0] seq [7];
        int done_count;
        seq = '{W_FETCH, W_DECODE, W_RTEXE, W_RTEXE, W_RTEXE, W_RTEXE, W_RTWB};
        done_count = 0;
        opcode = 6'b000000;
        funct  = 6'b001111;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ctrl !== seq[i]) begin
                errors++;
                $display("FAIL r_mul cycle %0d: got %b expected %b", i + 1, ctrl, seq[i]);
            end
            if (instr_done === 1'b1) done_count++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL r_mul_done_pulses: got %0d expected 1", done_count);
        end
        checks++;
        if (ctrl !== W_FETCH) begin
            errors++;
            $display("FAIL r_mul_return_fetch: got %b expected %b", ctrl, W_FETCH);
        end
        funct = 6'b000000;
    endtask

    task automatic test_back_to_back();
        logic [19:0] seq [9];
        seq = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB,
                W_FETCH, W_DECODE, W_MEMADR, W_MEMWR};
        for (int i = 0; i < 9; i++) begin
            opcode = (i < 5) ? 6'b100011 : 6'b101011;
            checks++;
            if (ctrl !== seq[i]) begin
                errors++;
                $display("FAIL lw_sw cycle %0d: got %b expected %b", i + 1, ctrl, seq[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [19:0] seq [3];
        logic [5:0]  ops [3];
        logic        zs  [3];
        ops = '{6'b000100, 6'b000100, 6'b000010};
        zs  = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            seq = '{W_FETCH, W_DECODE, (k < 2) ? W_BEQ : W_JUMP};
            opcode = ops[k];
            zero   = zs[k];
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctrl !== seq[i]) begin
                    errors++;
                    $display("FAIL branch_%0d cycle %0d: got %b expected %b", k, i + 1, ctrl, seq[i]);
                end
                @(posedge clk);
                #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_immediate();
        logic [19:0] seq [4];
        logic [5:0]  ops [3];
        logic [19:0] ex  [3];
        logic [19:0] wb  [3];
        ops = '{6'b001000, 6'b001100, 6'b001010};
        ex  = '{W_IEXE_A, W_IEXE_N, W_IEXE_S};
        wb  = '{W_IWB_A, W_IWB_N, W_IWB_S};
        for (int k = 0; k < 3; k++) begin
            seq = '{W_FETCH, W_DECODE, ex[k], wb[k]};
            opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ctrl !== seq[i]) begin
                    errors++;
                    $display("FAIL imm_%0d cycle %0d: got %b expected %b", k, i + 1, ctrl, seq[i]);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [19:0] seq [3];
        seq = '{W_FETCH, W_DECILL, W_FETCH};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctrl !== seq[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %b expected %b", i + 1, ctrl, seq[i]);
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_lw();
        test_r_add();
        test_r_mul();
        test_back_to_back();
        test_branch_jump();
        test_immediate();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
